// File: rtl/ex_mem_branch_resolve_if.sv
// EX-stage branch bundle between ID/EX, EX/MEM and fetch.
// Stats outputs exist only when BRANCH_STATS_EN is defined.
interface ex_mem_branch_resolve_if #(
  parameter int ADDR_W = 32
);
  logic              stall;
  logic              ID_EX_valid;
  logic              ID_EX_branch;
  logic              ID_EX_bne;
  logic [ADDR_W-1:0] ID_EX_npc;
  logic [31:0]       ID_EX_imm;
  logic              alu_zero;
  logic              EX_MEM_PCSrc;
  logic [ADDR_W-1:0] EX_MEM_NPC;
  logic              flush;
  logic              squashing;
`ifdef BRANCH_STATS_EN
  logic [15:0]       stat_branches;
  logic [15:0]       stat_taken;
`endif

  modport master (
    output stall, ID_EX_valid, ID_EX_branch, ID_EX_bne,
    output ID_EX_npc, ID_EX_imm, alu_zero,
`ifdef BRANCH_STATS_EN
    input  stat_branches, stat_taken,
`endif
    input  EX_MEM_PCSrc, EX_MEM_NPC, flush, squashing
  );

  modport slave (
    input  stall, ID_EX_valid, ID_EX_branch, ID_EX_bne,
    input  ID_EX_npc, ID_EX_imm, alu_zero,
`ifdef BRANCH_STATS_EN
    output stat_branches, stat_taken,
`endif
    output EX_MEM_PCSrc, EX_MEM_NPC, flush, squashing
  );
endinterface

// File: rtl/ex_mem_branch_resolve.sv
// EX branch resolve, EX/MEM redirect register and wrong-path squash FSM.
// Optional BRANCH_STATS_EN adds branch/taken counters.
module ex_mem_branch_resolve #(
  parameter int SQUASH_DEPTH = 2,
  parameter int ADDR_W       = 32
) (
  input logic                   clk,
  input logic                   rst_n,
  ex_mem_branch_resolve_if.slave bus
);

  if (SQUASH_DEPTH < 1 || SQUASH_DEPTH > 7) begin : g_bad_depth
    $error("SQUASH_DEPTH must be 1..7");
  end

  typedef enum logic {
    IDLE,
    SQUASH
  } state_t;

  state_t            r_state, w_state_n;
  logic [2:0]        r_cnt, w_cnt_n;
  logic              r_pcsrc, w_pcsrc_n;
  logic [ADDR_W-1:0] r_npc, w_npc_n;
  logic              r_flush, w_flush_n;

  logic              w_cond;
  logic              w_take;
  logic              w_resolve;
  logic [ADDR_W-1:0] w_imm_ext;
  logic [ADDR_W-1:0] w_target;

  // word offset, sign carried into the address width
  assign w_imm_ext = ADDR_W'($signed(bus.ID_EX_imm));
  assign w_target  = bus.ID_EX_npc + (w_imm_ext << 2);

  assign w_cond    = bus.ID_EX_bne ? !bus.alu_zero : bus.alu_zero;
  assign w_resolve = bus.ID_EX_valid & bus.ID_EX_branch
                   & (r_state == IDLE);
  assign w_take    = w_resolve & w_cond;

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_pcsrc_n = r_pcsrc;
    w_npc_n   = r_npc;
    w_flush_n = r_flush;
    if (!bus.stall) begin
      w_pcsrc_n = w_take;
      w_npc_n   = w_take ? w_target : bus.ID_EX_npc;
      unique case (r_state)
        IDLE: begin
          if (w_take) begin
            w_state_n = SQUASH;
            w_cnt_n   = 3'(SQUASH_DEPTH);
            w_flush_n = 1'b1;
          end
        end
        SQUASH: begin
          // bubbles never occupy a squash slot
          if (bus.ID_EX_valid) begin
            w_cnt_n = r_cnt - 3'd1;
            if (r_cnt == 3'd1) begin
              w_state_n = IDLE;
              w_flush_n = 1'b0;
            end
          end
        end
        default: begin
          w_state_n = IDLE;
          w_flush_n = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
      r_pcsrc <= 1'b0;
      r_npc   <= '0;
      r_flush <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_pcsrc <= w_pcsrc_n;
      r_npc   <= w_npc_n;
      r_flush <= w_flush_n;
    end
  end

  assign bus.EX_MEM_PCSrc = r_pcsrc;
  assign bus.EX_MEM_NPC   = r_npc;
  assign bus.flush        = r_flush;
  assign bus.squashing    = (r_state == SQUASH);

`ifdef BRANCH_STATS_EN
  logic [15:0] r_stat_br;
  logic [15:0] r_stat_tk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_br <= 16'd0;
      r_stat_tk <= 16'd0;
    end else if (!bus.stall) begin
      if (w_resolve) r_stat_br <= r_stat_br + 16'd1;
      if (w_take)    r_stat_tk <= r_stat_tk + 16'd1;
    end
  end

  assign bus.stat_branches = r_stat_br;
  assign bus.stat_taken    = r_stat_tk;
`endif

endmodule

// File: doc/ex_mem_branch_resolve.md
Name: ex_mem_branch_resolve

Overview:
- EX-stage branch resolver and EX/MEM branch register for the MIPS pipeline.
- Computes the branch target from the ID/EX next-PC and sign-extended immediate, then decides taken/not-taken from the ALU zero flag.
- Registers EX_MEM_PCSrc and EX_MEM_NPC, which the fetch stage consumes as its redirect.
- After a taken branch, squashes the wrong-path instructions behind it using a flush FSM.

Parameters:
- SQUASH_DEPTH, 2: number of EX-valid cycles squashed after a taken branch; legal range 1–7.
- ADDR_W, 32: PC/address width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold: all registers and the FSM keep their state
- ID_EX_valid  in  1  instruction in EX is real (not a bubble)
- ID_EX_branch  in  1  instruction in EX is a conditional branch
- ID_EX_bne  in  1  1 = bne (taken on !zero), 0 = beq (taken on zero); ignored unless branch
- ID_EX_npc  in  ADDR_W  PC+4 of the instruction in EX
- ID_EX_imm  in  32  sign-extended 16-bit offset, in words
- alu_zero  in  1  ALU zero flag for the instruction in EX
- EX_MEM_PCSrc  out  1  registered taken-branch redirect to fetch
- EX_MEM_NPC  out  ADDR_W  registered branch target (or npc when not taken)
- flush  out  1  registered; kills the IF/ID and ID/EX contents this cycle
- squashing  out  1  FSM is in SQUASH (debug/visibility)

Behaviour:
- Reset (async, rst_n=0): EX_MEM_PCSrc=0, EX_MEM_NPC=0, flush=0, squashing=0, FSM=IDLE, squash counter=0. Deassertion takes effect at the next clk edge.
- Target: target = ID_EX_npc + (ID_EX_imm << 2), truncated to ADDR_W. Wrap-around is modulo 2^ADDR_W with no saturation.
- Condition: cond = ID_EX_bne ? !alu_zero : alu_zero.
- take = ID_EX_valid & ID_EX_branch & cond & (state==IDLE).
- Latency: one cycle, EX inputs to EX/MEM outputs.
- Each non-stalled edge:
  - EX_MEM_PCSrc <= take.
  - EX_MEM_NPC <= take ? target : ID_EX_npc.
- EX_MEM_PCSrc is a single-cycle pulse per taken branch unless stall holds it.
- stall=1: every register holds, including PCSrc, NPC, flush, FSM and counter. A held PCSrc=1 re-presents the same target to fetch; this is idempotent.
- FSM states: IDLE, SQUASH.
  - IDLE -> SQUASH on take (non-stalled edge); counter <= SQUASH_DEPTH; flush <= 1.
  - In SQUASH, each non-stalled edge with ID_EX_valid=1 decrements the counter. Bubbles (valid=0) do not count.
  - SQUASH -> IDLE on the edge where counter reaches 0; flush <= 0 on that same edge.
  - While in SQUASH: flush=1 and squashing=1.
- In SQUASH, branches in EX are never resolved (take=0), and EX_MEM_NPC follows ID_EX_npc.
  - Consequence: of two back-to-back taken branches, only the first redirects.
- Non-branch or invalid instruction in EX: PCSrc <= 0, NPC <= ID_EX_npc.
- Reset asserted mid-SQUASH: the block returns to IDLE immediately, all outputs go to 0, and no residual flush remains.
- take and stall in the same cycle: nothing is captured. The branch is resolved on the first non-stalled edge, provided the inputs are still present.

Optional Feature:
- Macro: BRANCH_STATS_EN
- Defined:
  - Adds outputs stat_branches[15:0] (count of resolved branches, i.e. valid & branch & IDLE) and stat_taken[15:0] (count of take).
  - Both are reset to 0 by rst_n, frozen by stall, and wrap from 0xFFFF to 0.
- Undefined: the ports and counters are absent, and all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> EX_MEM_PCSrc=0, EX_MEM_NPC=0, flush=0. Assert rst_n asynchronously between edges -> outputs clear without a clock.
- beq taken: valid=1, branch=1, bne=0, zero=1, npc=400, imm=33 -> next edge PCSrc=1, NPC=532, flush=1. With SQUASH_DEPTH=2 and two valid cycles, flush falls at the edge of the second one.
- bne not taken: bne=1, zero=1, npc=1000, imm=5 -> PCSrc=0, NPC=1000, FSM stays in IDLE.
- Negative offset and wrap: npc=4, imm=0xFFFFFFFE -> NPC=0xFFFFFFFC. With npc=0xFFFFFFF0 and imm=8 -> NPC=0x10.
- Back-to-back plus bubble: taken branch, next cycle another taken branch, then a bubble, then a valid instruction -> only the first PCSrc pulse. The squash covers the second branch and the post-bubble instruction; the bubble is not counted.
- Stall and reset mid-squash: stall=1 for 3 cycles during SQUASH -> counter, flush and PCSrc are held. Then rst_n=0 -> IDLE, all outputs 0. With BRANCH_STATS_EN defined, check stat_branches and stat_taken counts across the sequence.
